// File: rtl/spi_controller_mode.sv
// Full-duplex SPI controller: all four CPOL/CPHA modes, programmable SCK divider, N active-low chip selects.
// Optional LSB-first framing is compiled in with `define SPI_CTRL_LSB_FIRST_EN (adds the lsb_first input).
module spi_controller_mode #(
    parameter int DATA_WIDTH = 8,
    parameter int CS_COUNT   = 4,
    parameter int CS_SEL_W   = 2,
    parameter int DIV_WIDTH  = 8,
    parameter int CNT_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  ready,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic [CS_SEL_W-1:0]   cs_sel,
    input  logic                  cpol,
    input  logic                  cpha,
    input  logic [DIV_WIDTH-1:0]  clk_div,
`ifdef SPI_CTRL_LSB_FIRST_EN
    input  logic                  lsb_first,
`endif
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  SCK,
    output logic                  COPI,
    input  logic                  CIPO,
    output logic [CS_COUNT-1:0]   CS_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        XFER  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] LAST_EDGE = CNT_WIDTH'(2 * DATA_WIDTH);
    localparam logic [DIV_WIDTH:0]   DIV_ONE   = (DIV_WIDTH + 1)'(1);

    state_t                state_q, state_d;
    logic [DIV_WIDTH:0]    halfPer_q, halfPer_d;
    logic [DIV_WIDTH:0]    divCnt_q, divCnt_d;
    logic [CNT_WIDTH-1:0]  edgeCnt_q, edgeCnt_d;
    logic                  cpol_q, cpol_d;
    logic                  cpha_q, cpha_d;
    logic                  lsbFirst_q, lsbFirst_d;
    logic [DATA_WIDTH-1:0] txShift_q, txShift_d;
    logic [DATA_WIDTH-1:0] rxShift_q, rxShift_d;
    logic [DATA_WIDTH-1:0] rxData_q, rxData_d;
    logic                  rxValid_q, rxValid_d;
    logic                  sck_q, sck_d;
    logic                  copi_q, copi_d;
    logic [CS_COUNT-1:0]   cs_q, cs_d;

    logic                  lsbFirstIn;
    logic [CS_COUNT-1:0]   csDecode;
    logic [CNT_WIDTH-1:0]  nextEdge;
    logic                  lastTick;
    logic                  leadingEdge;
    logic                  doToggle;
    logic                  txBit;
    logic [DATA_WIDTH-1:0] txShifted;

`ifdef SPI_CTRL_LSB_FIRST_EN
    assign lsbFirstIn = lsb_first;
`else
    assign lsbFirstIn = 1'b0;
`endif

    // Out-of-range selects leave every line deasserted; the frame still runs.
    always_comb begin
        csDecode = '1;
        for (int i = 0; i < CS_COUNT; i++) begin
            if (32'(cs_sel) == i) begin
                csDecode[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            halfPer_q  <= DIV_ONE;
            divCnt_q   <= '0;
            edgeCnt_q  <= '0;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            lsbFirst_q <= 1'b0;
            txShift_q  <= '0;
            rxShift_q  <= '0;
            rxData_q   <= '0;
            rxValid_q  <= 1'b0;
            sck_q      <= 1'b0;
            copi_q     <= 1'b0;
            cs_q       <= '1;
        end else begin
            state_q    <= state_d;
            halfPer_q  <= halfPer_d;
            divCnt_q   <= divCnt_d;
            edgeCnt_q  <= edgeCnt_d;
            cpol_q     <= cpol_d;
            cpha_q     <= cpha_d;
            lsbFirst_q <= lsbFirst_d;
            txShift_q  <= txShift_d;
            rxShift_q  <= rxShift_d;
            rxData_q   <= rxData_d;
            rxValid_q  <= rxValid_d;
            sck_q      <= sck_d;
            copi_q     <= copi_d;
            cs_q       <= cs_d;
        end
    end

    // Every phase is a whole number of H-cycle segments; an SCK toggle opens each XFER segment.
    always_comb begin
        state_d    = state_q;
        halfPer_d  = halfPer_q;
        divCnt_d   = divCnt_q;
        edgeCnt_d  = edgeCnt_q;
        cpol_d     = cpol_q;
        cpha_d     = cpha_q;
        lsbFirst_d = lsbFirst_q;
        txShift_d  = txShift_q;
        rxShift_d  = rxShift_q;
        rxData_d   = rxData_q;
        rxValid_d  = 1'b0;
        sck_d      = sck_q;
        copi_d     = copi_q;
        cs_d       = cs_q;
        doToggle   = 1'b0;

        lastTick    = ((divCnt_q + DIV_ONE) == halfPer_q);
        nextEdge    = edgeCnt_q + CNT_WIDTH'(1);
        leadingEdge = nextEdge[0];
        txBit       = lsbFirst_q ? txShift_q[0] : txShift_q[DATA_WIDTH-1];
        txShifted   = lsbFirst_q ? (txShift_q >> 1) : (txShift_q << 1);

        case (state_q)
            IDLE: begin
                sck_d     = cpol;
                copi_d    = 1'b0;
                divCnt_d  = '0;
                edgeCnt_d = '0;
                if (start) begin
                    state_d    = SETUP;
                    halfPer_d  = {1'b0, clk_div} + DIV_ONE;
                    cpol_d     = cpol;
                    cpha_d     = cpha;
                    lsbFirst_d = lsbFirstIn;
                    cs_d       = csDecode;
                    rxShift_d  = '0;
                    // With cpha=0 the peripheral samples on the first edge, so bit one must already be out.
                    if (cpha) begin
                        txShift_d = tx_data;
                    end else begin
                        copi_d    = lsbFirstIn ? tx_data[0] : tx_data[DATA_WIDTH-1];
                        txShift_d = lsbFirstIn ? (tx_data >> 1) : (tx_data << 1);
                    end
                end
            end
            SETUP: begin
                sck_d = cpol_q;
                if (lastTick) begin
                    divCnt_d = '0;
                    doToggle = 1'b1;
                    state_d  = XFER;
                end else begin
                    divCnt_d = divCnt_q + DIV_ONE;
                end
            end
            XFER: begin
                if (lastTick) begin
                    divCnt_d = '0;
                    if (edgeCnt_q == LAST_EDGE) begin
                        state_d = HOLD;
                    end else begin
                        doToggle = 1'b1;
                    end
                end else begin
                    divCnt_d = divCnt_q + DIV_ONE;
                end
            end
            HOLD: begin
                sck_d = cpol_q;
                if (lastTick) begin
                    state_d   = IDLE;
                    divCnt_d  = '0;
                    edgeCnt_d = '0;
                    cs_d      = '1;
                    copi_d    = 1'b0;
                    rxData_d  = rxShift_q;
                    rxValid_d = 1'b1;
                end else begin
                    divCnt_d = divCnt_q + DIV_ONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (doToggle) begin
            sck_d     = ~sck_q;
            edgeCnt_d = nextEdge;
            if (leadingEdge ^ cpha_q) begin
                rxShift_d = lsbFirst_q ? {CIPO, rxShift_q[DATA_WIDTH-1:1]}
                                       : {rxShift_q[DATA_WIDTH-2:0], CIPO};
            end else if (cpha_q || (nextEdge != LAST_EDGE)) begin
                copi_d    = txBit;
                txShift_d = txShifted;
            end
        end
    end

    assign ready    = (state_q == IDLE);
    assign rx_data  = rxData_q;
    assign rx_valid = rxValid_q;
    assign SCK      = sck_q;
    assign COPI     = copi_q;
    assign CS_out   = cs_q;

endmodule

// File: tb/tb_spi_controller_mode.sv
// Directed bench for spi_controller_mode: loopback and peripheral-model transfers in all four modes,
// chip-select decode, busy-start rejection, back-to-back accept and asynchronous reset mid-transfer.
module tb_spi_controller_mode;

    logic       clk;
    logic       rst;
    logic       start;
    logic       ready;
    logic [7:0] tx_data;
    logic [1:0] cs_sel;
    logic       cpol;
    logic       cpha;
    logic [7:0] clk_div;
    logic       lsbFirst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       SCK;
    logic       COPI;
    logic       CIPO;
    logic [3:0] CS_out;

    int checks = 0;
    int errors = 0;

    logic       loopback;
    logic       perCipo;
    logic [7:0] perTx;
    logic [7:0] perRx;
    int         perIdx;
    int         cycleNo;
    int         csLow;
    int         toggles;
    int         gapMin;
    int         gapMax;
    int         lastToggle;
    int         edgeViol;
    int         rxValidTotal;
    int         savedRxValid;
    logic       prevCsAct;
    logic       prevSck;
    logic       prevCopi;

    assign CIPO = loopback ? COPI : perCipo;

    spi_controller_mode #(
        .DATA_WIDTH(8),
        .CS_COUNT  (4),
        .CS_SEL_W  (2),
        .DIV_WIDTH (8),
        .CNT_WIDTH (5)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .ready    (ready),
        .tx_data  (tx_data),
        .cs_sel   (cs_sel),
        .cpol     (cpol),
        .cpha     (cpha),
        .clk_div  (clk_div),
`ifdef SPI_CTRL_LSB_FIRST_EN
        .lsb_first(lsbFirst),
`endif
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .SCK      (SCK),
        .COPI     (COPI),
        .CIPO     (CIPO),
        .CS_out   (CS_out)
    );

    // Free-running controller clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Bus monitor and peripheral model, evaluated mid-cycle when every registered output is stable.
    initial begin
        logic csAct;
        logic leading;
        cycleNo = 0; csLow = 0; toggles = 0; gapMin = 1000000; gapMax = 0;
        lastToggle = 0; edgeViol = 0; rxValidTotal = 0; perIdx = -1;
        perRx = 8'h00; perCipo = 1'b0;
        prevCsAct = 1'b0; prevSck = 1'b0; prevCopi = 1'b0;
        forever begin
            @(negedge clk);
            cycleNo++;
            csAct = (CS_out !== 4'hF);
            if (rx_valid === 1'b1) rxValidTotal++;
            if (csAct && !prevCsAct) begin
                csLow = 0; toggles = 0; gapMin = 1000000; gapMax = 0;
                lastToggle = cycleNo; perRx = 8'h00; perIdx = 7;
                if (!cpha) begin
                    perCipo = perTx[7];
                    perIdx  = 6;
                end
            end
            if (csAct) csLow++;
            if (csAct && prevCsAct && (SCK !== prevSck)) begin
                toggles++;
                if ((cycleNo - lastToggle) < gapMin) gapMin = cycleNo - lastToggle;
                if ((cycleNo - lastToggle) > gapMax) gapMax = cycleNo - lastToggle;
                lastToggle = cycleNo;
                leading = (SCK !== cpol);
                if (leading ^ cpha) begin
                    if (COPI !== prevCopi) edgeViol++;
                    perRx = {perRx[6:0], COPI};
                end else if (perIdx >= 0) begin
                    perCipo = perTx[perIdx];
                    perIdx--;
                end
            end
            prevCsAct = csAct;
            prevSck   = SCK;
            prevCopi  = COPI;
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] tx, input logic [1:0] sel, input logic pol,
                                 input logic pha, input logic [7:0] div);
        tx_data = tx;
        cs_sel  = sel;
        cpol    = pol;
        cpha    = pha;
        clk_div = div;
        start   = 1'b1;
        step();
        start   = 1'b0;
    endtask

    task automatic waitDone(input string tag, input int budget);
        int n = 0;
        while (rx_valid !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        checkOutput({tag, "_done"}, 32'(rx_valid), 32'h1);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; tx_data = 8'h00; cs_sel = 2'd0; cpol = 1'b0; cpha = 1'b0;
        clk_div = 8'd0; lsbFirst = 1'b0; loopback = 1'b1; perTx = 8'h00; savedRxValid = 0;
        #1 rst = 1'b0;
        repeat (3) step();
        checkOutput("reset_ready", 32'(ready), 32'h1);
        checkOutput("reset_rxvalid", 32'(rx_valid), 32'h0);
        checkOutput("reset_rxdata", 32'(rx_data), 32'h0);
        checkOutput("reset_sck", 32'(SCK), 32'h0);
        checkOutput("reset_copi", 32'(COPI), 32'h0);
        checkOutput("reset_cs", 32'(CS_out), 32'hF);
        rst = 1'b1;
        repeat (2) step();

        $display("[TB] mode 0 loopback, divider 0");
        applyStimulus(8'hA5, 2'd0, 1'b0, 1'b0, 8'd0);
        checkOutput("t1_ready", 32'(ready), 32'h0);
        checkOutput("t1_cs", 32'(CS_out), 32'hE);
        checkOutput("t1_copi_first", 32'(COPI), 32'h1);
        checkOutput("t1_sck_setup", 32'(SCK), 32'h0);
        waitDone("t1", 100);
        checkOutput("t1_rx", 32'(rx_data), 32'hA5);
        checkOutput("t1_cs_low", 32'(csLow), 32'd18);
        checkOutput("t1_toggles", 32'(toggles), 32'd16);
        checkOutput("t1_gap", 32'(gapMax), 32'd1);
        checkOutput("t1_sck_idle", 32'(SCK), 32'h0);
        checkOutput("t1_cs_done", 32'(CS_out), 32'hF);
        checkOutput("t1_ready_done", 32'(ready), 32'h1);
        checkOutput("t1_edge_rule", 32'(edgeViol), 32'd0);
        step();
        checkOutput("t1_rxvalid_pulse", 32'(rx_valid), 32'h0);

        $display("[TB] mode 3 with peripheral model, divider 3");
        loopback = 1'b0; perTx = 8'h3C; cpol = 1'b1;
        repeat (2) step();
        checkOutput("t2_sck_idle_pre", 32'(SCK), 32'h1);
        applyStimulus(8'hC3, 2'd1, 1'b1, 1'b1, 8'd3);
        checkOutput("t2_cs", 32'(CS_out), 32'hD);
        checkOutput("t2_copi_setup", 32'(COPI), 32'h0);
        checkOutput("t2_sck_setup", 32'(SCK), 32'h1);
        waitDone("t2", 200);
        checkOutput("t2_rx", 32'(rx_data), 32'h3C);
        checkOutput("t2_per_rx", 32'(perRx), 32'hC3);
        checkOutput("t2_cs_low", 32'(csLow), 32'd72);
        checkOutput("t2_toggles", 32'(toggles), 32'd16);
        checkOutput("t2_gap_min", 32'(gapMin), 32'd4);
        checkOutput("t2_gap_max", 32'(gapMax), 32'd4);
        checkOutput("t2_sck_idle", 32'(SCK), 32'h1);
        checkOutput("t2_edge_rule", 32'(edgeViol), 32'd0);
        step();
        checkOutput("t2_rxvalid_pulse", 32'(rx_valid), 32'h0);

        $display("[TB] modes 1 and 2 loopback");
        loopback = 1'b1;
        applyStimulus(8'h81, 2'd0, 1'b0, 1'b1, 8'd0);
        checkOutput("t3m1_copi_setup", 32'(COPI), 32'h0);
        waitDone("t3m1", 100);
        checkOutput("t3m1_rx", 32'(rx_data), 32'h81);
        checkOutput("t3m1_toggles", 32'(toggles), 32'd16);
        checkOutput("t3m1_cs_low", 32'(csLow), 32'd18);
        checkOutput("t3m1_edge_rule", 32'(edgeViol), 32'd0);
        step();
        applyStimulus(8'h81, 2'd0, 1'b1, 1'b0, 8'd1);
        checkOutput("t3m2_copi_first", 32'(COPI), 32'h1);
        checkOutput("t3m2_sck_setup", 32'(SCK), 32'h1);
        waitDone("t3m2", 100);
        checkOutput("t3m2_rx", 32'(rx_data), 32'h81);
        checkOutput("t3m2_cs_low", 32'(csLow), 32'd36);
        checkOutput("t3m2_sck_idle", 32'(SCK), 32'h1);
        checkOutput("t3m2_edge_rule", 32'(edgeViol), 32'd0);
        step();

        $display("[TB] chip-select decode and mid-transfer cs_sel change");
        applyStimulus(8'h3C, 2'd2, 1'b0, 1'b0, 8'd0);
        checkOutput("t4_cs_start", 32'(CS_out), 32'hB);
        repeat (3) step();
        cs_sel = 2'd0;
        repeat (2) step();
        checkOutput("t4_cs_mid1", 32'(CS_out), 32'hB);
        repeat (4) step();
        checkOutput("t4_cs_mid2", 32'(CS_out), 32'hB);
        waitDone("t4", 100);
        checkOutput("t4_rx", 32'(rx_data), 32'h3C);
        checkOutput("t4_cs_done", 32'(CS_out), 32'hF);
        step();
        checkOutput("t4_cs_after", 32'(CS_out), 32'hF);

        $display("[TB] busy starts ignored, held start accepted on completion");
        applyStimulus(8'h66, 2'd0, 1'b0, 1'b0, 8'd1);
        repeat (2) step();
        tx_data = 8'hFF; cs_sel = 2'd3; start = 1'b1;
        step();
        start = 1'b0;
        checkOutput("t5_ign1_cs", 32'(CS_out), 32'hE);
        checkOutput("t5_ign1_ready", 32'(ready), 32'h0);
        repeat (6) step();
        start = 1'b1;
        step();
        start = 1'b0;
        checkOutput("t5_ign2_cs", 32'(CS_out), 32'hE);
        checkOutput("t5_ign2_ready", 32'(ready), 32'h0);
        tx_data = 8'h99; cs_sel = 2'd1; start = 1'b1;
        waitDone("t5a", 200);
        checkOutput("t5a_rx", 32'(rx_data), 32'h66);
        checkOutput("t5a_cs_gap", 32'(CS_out), 32'hF);
        checkOutput("t5a_ready", 32'(ready), 32'h1);
        step();
        start = 1'b0;
        checkOutput("t5b_cs", 32'(CS_out), 32'hD);
        checkOutput("t5b_ready", 32'(ready), 32'h0);
        checkOutput("t5b_rxvalid_low", 32'(rx_valid), 32'h0);
        waitDone("t5b", 200);
        checkOutput("t5b_rx", 32'(rx_data), 32'h99);
        checkOutput("t5b_cs_low", 32'(csLow), 32'd36);
        step();

        $display("[TB] asynchronous reset mid-transfer");
        applyStimulus(8'h77, 2'd0, 1'b0, 1'b0, 8'd2);
        repeat (9) step();
        checkOutput("t6_pre_sck", 32'(SCK), 32'h1);
        checkOutput("t6_pre_copi", 32'(COPI), 32'h1);
        checkOutput("t6_pre_cs", 32'(CS_out), 32'hE);
        savedRxValid = rxValidTotal;
        rst = 1'b0;
        #1;
        checkOutput("t6_rst_cs", 32'(CS_out), 32'hF);
        checkOutput("t6_rst_sck", 32'(SCK), 32'h0);
        checkOutput("t6_rst_copi", 32'(COPI), 32'h0);
        checkOutput("t6_rst_ready", 32'(ready), 32'h1);
        checkOutput("t6_rst_rxvalid", 32'(rx_valid), 32'h0);
        repeat (3) step();
        rst = 1'b1;
        repeat (20) step();
        checkOutput("t6_no_rxvalid", 32'(rxValidTotal), 32'(savedRxValid));
        applyStimulus(8'h5A, 2'd0, 1'b0, 1'b0, 8'd0);
        waitDone("t6", 100);
        checkOutput("t6_rx", 32'(rx_data), 32'h5A);
        checkOutput("t6_cs_low", 32'(csLow), 32'd18);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
